// File: rtl/ddr_rd_bw_ctrl.sv
// ddr_rd_bw_ctrl: AXI4 read master for the DDR bandwidth test.
// A rising edge on start launches num_bursts fixed-length INCR bursts from an
// aligned base address. Up to MAX_OUT bursts are kept in flight. Every returned
// beat is folded into a 32-bit checksum, and cycle, beat, burst and error
// counters are exported on the probe bus.
module ddr_rd_bw_ctrl #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int MAX_OUT   = 4
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_areset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [15:0]       num_bursts,
    output logic [31:0]       partial_sum,
    output logic [159:0]      probe,
    output logic [31:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int          LANES        = DATA_W / 32;
    localparam int          BURST_BYTES  = BURST_LEN * (DATA_W / 8);
    localparam int          ALIGN_W      = $clog2(BURST_BYTES);
    localparam logic [31:0] ALIGN_MASK   = ~((32'd1 << ALIGN_W) - 32'd1);
    localparam logic [31:0] BURST_STRIDE = 32'(BURST_BYTES);
    localparam logic [3:0]  OUT_CAP      = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  state_bits;
    logic        start_d;
    logic        go;
    logic [31:0] base_q;
    logic [15:0] nb_q;
    logic [15:0] issued;
    logic [15:0] issued_nxt;
    logic [3:0]  out_cnt;
    logic [3:0]  out_nxt;
    logic [31:0] beats;
    logic [31:0] cycles;
    logic [31:0] err_cnt;
    logic        err_f;
    logic        done_f;
    logic        ar_hs;
    logic        r_hs;
    logic        last_beat;
    logic [31:0] total_beats;
    logic        arvalid_nxt;
    logic [31:0] araddr_nxt;

    // Sum of all 32-bit lanes of one data beat, modulo 2^32.
    function automatic logic [31:0] lane_sum(input logic [DATA_W-1:0] d);
        logic [31:0] acc;
        acc = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            acc = acc + d[32*i +: 32];
        end
        return acc;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = (state == RUN);
    assign state_bits    = state;

    assign go          = start & ~start_d;
    assign ar_hs       = m_axi_arvalid & m_axi_arready;
    assign r_hs        = m_axi_rvalid & m_axi_rready;
    assign total_beats = 32'(nb_q) * 32'(BURST_LEN);
    assign last_beat   = r_hs && ((beats + 32'd1) == total_beats);

    // Next state plus next AR-channel values. A pending AR is held until accepted.
    always_comb begin
        state_nxt   = state;
        issued_nxt  = issued + {15'd0, ar_hs};
        out_nxt     = out_cnt + {3'd0, ar_hs} - {3'd0, r_hs & m_axi_rlast};
        arvalid_nxt = 1'b0;
        araddr_nxt  = m_axi_araddr;
        unique case (state)
            IDLE, DONE: if (go) state_nxt = RUN;
            RUN:        if ((nb_q == 16'd0) || last_beat) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if ((state == RUN) && (state_nxt == RUN)) begin
            if (m_axi_arvalid && !m_axi_arready) begin
                arvalid_nxt = 1'b1;
            end else if ((issued_nxt < nb_q) && (out_nxt < OUT_CAP)) begin
                arvalid_nxt = 1'b1;
                araddr_nxt  = base_q + 32'(issued_nxt) * BURST_STRIDE;
            end
        end
    end

    // State register.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) state <= IDLE;
        else              state <= state_nxt;
    end

    // Run bookkeeping: latch run parameters on go, then count and accumulate while running.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            start_d       <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= 32'd0;
            base_q        <= 32'd0;
            nb_q          <= 16'd0;
            issued        <= 16'd0;
            out_cnt       <= 4'd0;
            beats         <= 32'd0;
            cycles        <= 32'd0;
            err_cnt       <= 32'd0;
            err_f         <= 1'b0;
            done_f        <= 1'b0;
            partial_sum   <= 32'd0;
        end else begin
            start_d       <= start;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_araddr  <= araddr_nxt;
            if ((state != RUN) && go) begin
                base_q      <= base_addr & ALIGN_MASK;
                nb_q        <= num_bursts;
                issued      <= 16'd0;
                out_cnt     <= 4'd0;
                beats       <= 32'd0;
                cycles      <= 32'd0;
                err_cnt     <= 32'd0;
                err_f       <= 1'b0;
                done_f      <= 1'b0;
                partial_sum <= 32'd0;
            end else if (state == RUN) begin
                cycles  <= cycles + 32'd1;
                issued  <= issued_nxt;
                out_cnt <= out_nxt;
                if (r_hs) begin
                    beats       <= beats + 32'd1;
                    partial_sum <= partial_sum + lane_sum(m_axi_rdata);
                    if (m_axi_rresp != 2'b00) begin
                        err_cnt <= sat_inc(err_cnt);
                        err_f   <= 1'b1;
                    end
                end
                if (state_nxt == DONE) done_f <= 1'b1;
            end
        end
    end

    // Registered status snapshot for the register-slave probe bus.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            probe <= 160'd0;
        end else begin
            probe <= {20'd0, out_cnt, 3'd0, err_f, done_f, (state == RUN), state_bits,
                      err_cnt, 16'd0, issued, beats, cycles};
        end
    end

endmodule
